m1_round_ctrl: RTL and testbench
================================

// Module: m1_round_ctrl
// PURPOSE
//  SHA-256 compression controller feeding m1_abc_reg: owns message schedule, K ROM and round FSM.
//  Per round computes new A (T1+T2) and new E (d+T1) from current a..h; the register stage shifts.
//  Loads midstate into the a..h chain, runs 64 rounds, adds feed-forward, presents 256-bit digest.
// PARAMETERS
//  ROUNDS      64   rounds per block (fixed for SHA-256; the bench may not change it)
//  LOAD_CYC    4    cycles to shift the midstate into the a..d / e..h chains
// PORTS
//  clk_h          in   1    single clock, all logic rising-edge
//  rst_h          in   1    synchronous, active-high reset
//  start          in   1    begin block; sampled only in IDLE
//  blk_in         in   512  message block, W0 = [511:480] ... W15 = [31:0]; latched on start
//  mid_in         in   256  midstate H0 = [255:224] ... H7 = [31:0]; latched on start
//  a,b,c,d,e,f,g,h in  32   current working state from m1_abc_reg
//  m1_abc_data_in out  32   value shifted into a (new A / midstate word)
//  m1_e_data_in   out  32   value shifted into e (new E / midstate word)
//  m1_abc_en      out  1    shift enable to m1_abc_reg
//  busy           out  1    high from the cycle after start until done
//  done           out  1    one-cycle pulse; digest valid from then until next start
//  digest         out  256  H + final a..h, word order as mid_in
// BEHAVIOUR
//  Reset: state=IDLE; m1_abc_en=0, busy=0, done=0, digest=0, data outs=0, round ctr=0.
//  m1_abc_reg contract: a..h reflect a shift one clk_h after m1_abc_en=1.
//  FSM IDLE -> LOAD -> ROUND -> FINAL -> IDLE.
//   IDLE: start=1 latches blk_in, mid_in, W window <= W0..W15; next LOAD. start=0 -> hold.
//   LOAD (k=0..3): abc_in=H[3-k], e_in=H[7-k], en=1 -> H3..H0 land in d..a, H7..H4 land in h..e.
//   ROUND (t=0..63): en=1; T1=h+S1(e)+Ch(e,f,g)+K[t]+W[t]; T2=S0(a)+Maj(a,b,c);
//    abc_in=T1+T2, e_in=d+T1; all sums mod 2^32, combinational from a..h, registered outs not used.
//    W[t] = window head; window shifts every round, new W = s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16].
//   FINAL: en=0; digest word i <= H[i] + state word i (mod 2^32); next cycle done=1, state IDLE.
//  Latency: start in cycle 0 -> LOAD 1..4 -> ROUND 5..68 -> FINAL 69 -> done=1 in cycle 70.
//  m1_abc_en=0 in IDLE and FINAL; never asserted two cycles after rst_h.
//  start while busy: ignored, no effect on latched inputs. start same cycle as done: accepted.
//  rst_h mid-block: abort next edge, outputs to reset values, digest cleared, no done pulse.
//  Round counter 6 bits, wraps 63->0 only on ROUND->FINAL transition.
// CONFIGURATION
//  M1_TARGET_CHK_EN defined: extra output hit (1 bit), registered with digest;
//   hit=1 iff digest word H7 == 32'h0 (mining early target); cleared on start and reset.
//  Undefined: no hit port, no comparator; all other behaviour identical.
// STRUCTURE
//  Package m1_sha_pkg: K[0:63] constant table, ROUNDS, LOAD_CYC, state enum, functions
//   S0/S1/s0/s1/Ch/Maj on 32-bit words.
//  One sub-module: m1_msg_sched (16x32 W window, load/shift ports, W[t] out).
//  FSM, counter, T1/T2 datapath and feed-forward stay in the top module.
// TESTING
//  Bench instantiates m1_round_ctrl + m1_abc_reg closed loop; golden model in package functions.
//  1 "abc" padded block, mid_in=SHA-256 IV -> done at cycle 70, digest=ba7816bf...f20015ad.
//  2 Empty-message padded block, IV -> digest=e3b0c442...7852b855.
//  3 start pulsed at cycles 10 and 40 of a run -> second ignored; digest still matches test 1.
//  4 rst_h asserted at round 30 -> next cycle en=0, busy=0, digest=0; new start gives correct result.
//  5 Back-to-back: start on done cycle with test-2 inputs -> both digests correct, no idle gap.
//  6 M1_TARGET_CHK_EN: block forcing H7==0 (precomputed vector) -> hit=1; test 1 -> hit=0.

Source files
------------

// File: rtl/m1_sha_pkg.sv
// rtl/m1_sha_pkg.sv - SHA-256 constants, FSM state type and round helper functions
// Purpose : shared by m1_round_ctrl and m1_msg_sched.
// Contents: ROUNDS, LOAD_CYC, state_e, K[0:63] round constants,
//           S0/S1 (compression sigmas), s0/s1 (schedule sigmas), Ch, Maj.
package m1_sha_pkg;

    localparam int ROUNDS   = 64;
    localparam int LOAD_CYC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FINAL = 2'd3
    } state_e;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] S0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] S1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] Ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/m1_msg_sched.sv
// rtl/m1_msg_sched.sv - SHA-256 message schedule, 16-word sliding W window
// Purpose : holds W[t..t+15]; head word is W[t] for the current round.
// Ports   : clk_h, rst_h (sync active-high), load_i + blk_i (W0 = [511:480]),
//           shift_i (advance one round), w_o (window head W[t]).
module m1_msg_sched
    import m1_sha_pkg::*;
(
    input  logic         clk_h,
    input  logic         rst_h,
    input  logic         load_i,
    input  logic [511:0] blk_i,
    input  logic         shift_i,
    output logic [31:0]  w_o
);

    logic [31:0] win_q [0:15];
    logic [31:0] w_new;

    // W[t+16] from the words currently at offsets 14, 9, 1 and 0 of the window
    assign w_new = s1(win_q[14]) + win_q[9] + s0(win_q[1]) + win_q[0];
    assign w_o   = win_q[0];

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else if (load_i) begin
            for (int i = 0; i < 16; i++) win_q[i] <= blk_i[511 - 32*i -: 32];
        end else if (shift_i) begin
            for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
            win_q[15] <= w_new;
        end
    end

endmodule

// File: rtl/m1_round_ctrl.sv
// rtl/m1_round_ctrl.sv - SHA-256 compression controller driving the m1_abc_reg shift chain
// Purpose : latches block + midstate, shifts the midstate into a..h, runs 64 rounds,
//           adds feed-forward and presents the digest.
// Ports   : clk_h, rst_h (sync active-high); start, blk_in[511:0], mid_in[255:0];
//           a..h working state in; m1_abc_data_in / m1_e_data_in / m1_abc_en to the
//           register chain; busy, done, digest[255:0].
// Option  : M1_TARGET_CHK_EN adds output hit (digest word H7 == 0), registered with digest.
module m1_round_ctrl
    import m1_sha_pkg::*;
(
    input  logic         clk_h,
    input  logic         rst_h,
    input  logic         start,
    input  logic [511:0] blk_in,
    input  logic [255:0] mid_in,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  logic [31:0]  c,
    input  logic [31:0]  d,
    input  logic [31:0]  e,
    input  logic [31:0]  f,
    input  logic [31:0]  g,
    input  logic [31:0]  h,
    output logic [31:0]  m1_abc_data_in,
    output logic [31:0]  m1_e_data_in,
    output logic         m1_abc_en,
    output logic         busy,
    output logic         done,
`ifdef M1_TARGET_CHK_EN
    output logic         hit,
`endif
    output logic [255:0] digest
);

    localparam logic [5:0] LOAD_LAST  = 6'(LOAD_CYC - 1);
    localparam logic [5:0] ROUND_LAST = 6'(ROUNDS - 1);

    state_e       state_q;
    logic [5:0]   ctr_q;
    logic         en_q;
    logic         busy_q;
    logic         done_q;
    logic [255:0] mid_q;
    logic [255:0] digest_q;
    logic [255:0] ffwd_d;
    logic         hit_q;

    logic [31:0]  h_w  [0:7];
    logic [31:0]  st_w [0:7];
    logic [31:0]  w_t;
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [1:0]   ld_idx;
    logic         sched_load;
    logic         sched_shift;

    assign sched_load  = (state_q == ST_IDLE) && start;
    assign sched_shift = (state_q == ST_ROUND);

    m1_msg_sched u_sched (
        .clk_h   (clk_h),
        .rst_h   (rst_h),
        .load_i  (sched_load),
        .blk_i   (blk_in),
        .shift_i (sched_shift),
        .w_o     (w_t)
    );

    always_comb begin
        for (int i = 0; i < 8; i++) h_w[i] = mid_q[255 - 32*i -: 32];
    end

    assign st_w = '{a, b, c, d, e, f, g, h};

    // Round datapath works directly off the live a..h so each round's result
    // is shifted in on the same edge that ends the round.
    assign t1 = h + S1(e) + Ch(e, f, g) + K[ctr_q] + w_t;
    assign t2 = S0(a) + Maj(a, b, c);

    // LOAD shifts H3..H0 into the abc side and H7..H4 into the e side, so the
    // last words shifted (H0, H4) end up at the heads a and e.
    assign ld_idx = 2'd3 - ctr_q[1:0];

    always_comb begin
        m1_abc_data_in = '0;
        m1_e_data_in   = '0;
        case (state_q)
            ST_LOAD: begin
                m1_abc_data_in = h_w[{1'b0, ld_idx}];
                m1_e_data_in   = h_w[{1'b1, ld_idx}];
            end
            ST_ROUND: begin
                m1_abc_data_in = t1 + t2;
                m1_e_data_in   = d + t1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ffwd_d = '0;
        for (int i = 0; i < 8; i++) ffwd_d[255 - 32*i -: 32] = h_w[i] + st_w[i];
    end

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            state_q  <= ST_IDLE;
            ctr_q    <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mid_q    <= '0;
            digest_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mid_q   <= mid_in;
                        ctr_q   <= '0;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        hit_q   <= 1'b0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ctr_q == LOAD_LAST) begin
                        ctr_q   <= '0;
                        state_q <= ST_ROUND;
                    end else begin
                        ctr_q <= ctr_q + 6'd1;
                    end
                end
                ST_ROUND: begin
                    // 6-bit counter rolls 63 -> 0 exactly as the FSM leaves ROUND
                    ctr_q <= ctr_q + 6'd1;
                    if (ctr_q == ROUND_LAST) begin
                        en_q    <= 1'b0;
                        state_q <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    digest_q <= ffwd_d;
                    hit_q    <= (ffwd_d[31:0] == 32'h0);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m1_abc_en = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign digest    = digest_q;

`ifdef M1_TARGET_CHK_EN
    assign hit = hit_q;
`else
    // Without the target check the flag register is dead and is trimmed away.
    logic unused_hit;
    assign unused_hit = hit_q;
`endif

endmodule

// File: tb/tb_m1_round_ctrl.sv
// tb/tb_m1_round_ctrl.sv - self-checking bench for m1_round_ctrl with a behavioural a..h chain
module tb_m1_round_ctrl;
    import m1_sha_pkg::*;

    logic         clk_h = 1'b0;
    logic         rst_h = 1'b1;
    logic         start = 1'b0;
    logic [511:0] blk_in = '0;
    logic [255:0] mid_in = '0;
    logic [31:0]  a = '0, b = '0, c = '0, d = '0, e = '0, f = '0, g = '0, h = '0;
    logic [31:0]  m1_abc_data_in, m1_e_data_in;
    logic         m1_abc_en, busy, done;
    logic [255:0] digest;
`ifdef M1_TARGET_CHK_EN
    logic         hit;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_h = ~clk_h;

    m1_round_ctrl dut (
        .clk_h          (clk_h),
        .rst_h          (rst_h),
        .start          (start),
        .blk_in         (blk_in),
        .mid_in         (mid_in),
        .a              (a),
        .b              (b),
        .c              (c),
        .d              (d),
        .e              (e),
        .f              (f),
        .g              (g),
        .h              (h),
        .m1_abc_data_in (m1_abc_data_in),
        .m1_e_data_in   (m1_e_data_in),
        .m1_abc_en      (m1_abc_en),
        .busy           (busy),
        .done           (done),
`ifdef M1_TARGET_CHK_EN
        .hit            (hit),
`endif
        .digest         (digest)
    );

    // Stand-in for m1_abc_reg: two 4-deep shift chains, a..d and e..h
    always_ff @(posedge clk_h) begin
        if (m1_abc_en) begin
            a <= m1_abc_data_in; b <= a; c <= b; d <= c;
            e <= m1_e_data_in;   f <= e; g <= f; h <= g;
        end
    end

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [511:0] BLK_ABC = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression in textbook form (full 64-word expansion, array rotation)
    function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] mid);
        logic [31:0] w [0:63];
        logic [31:0] v [0:7];
        logic [31:0] x1, x2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = mid[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = mid[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_h);
        @(negedge clk_h);
    endtask

    task automatic do_start(input logic [511:0] blk, input logic [255:0] mid);
        blk_in = blk;
        mid_in = mid;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    // Called one cycle after start (n = 1); returns the cycle index where done was seen.
    // Cycles pa/pb get a junk start pulse while the block is running.
    task automatic wait_done(input int pa, input int pb, output int lat,
                             output int en_cnt, output int busy_cnt);
        int n;
        n = 1; en_cnt = 0; busy_cnt = 0;
        while (!done && n < 200) begin
            en_cnt   += int'(m1_abc_en);
            busy_cnt += int'(busy);
            if (n == pa || n == pb) begin
                start  = 1'b1;
                blk_in = {16{32'hdeadbeef}};
                mid_in = '1;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        lat = n;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end
    endtask

    typedef struct {
        logic [511:0] blk;
        logic [255:0] mid;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs [0:3];
    int   lat, en_cnt, busy_cnt;

    initial begin
        vecs[0] = '{BLK_ABC, IV, DIG_ABC};
        vecs[1] = '{BLK_EMPTY, IV, DIG_EMPTY};
        vecs[2].blk = '0;
        for (int i = 0; i < 16; i++) vecs[2].blk[511 - 32*i -: 32] = 32'h01010101 * (i + 1);
        vecs[2].mid = DIG_ABC;
        vecs[2].exp = ref_compress(vecs[2].blk, vecs[2].mid);
        vecs[3].blk = {16{32'hffffffff}};
        vecs[3].mid = 256'h0;
        vecs[3].exp = ref_compress(vecs[3].blk, vecs[3].mid);

        // Reset state
        repeat (3) step();
        rst_h = 1'b0;
        chk("rst_en",     {255'h0, m1_abc_en}, 256'h0);
        chk("rst_busy",   {255'h0, busy},      256'h0);
        chk("rst_done",   {255'h0, done},      256'h0);
        chk("rst_digest", digest,              256'h0);
        chk("rst_data",   {192'h0, m1_abc_data_in, m1_e_data_in}, 256'h0);
        step();
        chk("rst_en_2cyc", {255'h0, m1_abc_en}, 256'h0);

        // Table-driven blocks
        for (int v = 0; v < 4; v++) begin
            do_start(vecs[v].blk, vecs[v].mid);
            wait_done(-1, -1, lat, en_cnt, busy_cnt);
            chk($sformatf("v%0d_digest", v),  digest, vecs[v].exp);
            chk($sformatf("v%0d_latency", v), 256'(lat), 256'd70);
            chk($sformatf("v%0d_en_cnt", v),  256'(en_cnt), 256'd68);
            chk($sformatf("v%0d_busy_cnt", v), 256'(busy_cnt), 256'd69);
            chk($sformatf("v%0d_busy_at_done", v), {255'h0, busy}, 256'h0);
`ifdef M1_TARGET_CHK_EN
            chk($sformatf("v%0d_hit", v), {255'h0, hit}, {255'h0, (vecs[v].exp[31:0] == 32'h0)});
`endif
            step();
            chk($sformatf("v%0d_done_pulse", v), {255'h0, done}, 256'h0);
            chk($sformatf("v%0d_digest_hold", v), digest, vecs[v].exp);
        end

        // start pulses while busy must be ignored
        do_start(BLK_ABC, IV);
        wait_done(10, 40, lat, en_cnt, busy_cnt);
        chk("busy_start_digest",  digest, DIG_ABC);
        chk("busy_start_latency", 256'(lat), 256'd70);
        step();
        chk("busy_start_no_restart", {255'h0, busy}, 256'h0);

        // Reset during round 30 (cycle 35)
        do_start(BLK_ABC, IV);
        repeat (34) step();
        chk("mid_run_en", {255'h0, m1_abc_en}, 256'h1);
        rst_h = 1'b1;
        step();
        rst_h = 1'b0;
        chk("abort_en",     {255'h0, m1_abc_en}, 256'h0);
        chk("abort_busy",   {255'h0, busy},      256'h0);
        chk("abort_digest", digest,              256'h0);
        repeat (40) begin
            if (done) begin
                n_tests++;
                n_fail++;
                $display("FAIL abort_no_done: got done=1 expected 0");
            end
            step();
        end
        do_start(BLK_ABC, IV);
        wait_done(-1, -1, lat, en_cnt, busy_cnt);
        chk("after_abort_digest", digest, DIG_ABC);

        // Back-to-back: next start on the done cycle
        step();
        do_start(BLK_ABC, IV);
        wait_done(-1, -1, lat, en_cnt, busy_cnt);
        chk("b2b_first_digest", digest, DIG_ABC);
        do_start(BLK_EMPTY, IV);
        wait_done(-1, -1, lat, en_cnt, busy_cnt);
        chk("b2b_second_digest",  digest, DIG_EMPTY);
        chk("b2b_second_latency", 256'(lat), 256'd70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
